dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory. The memory has a synchronous write and a combinational read.
- Shares the memory between the core load/store unit and a DMA/program-loader port.
- Registers each accepted request, drives the memory address, data, funct3 and write-enable for exactly one issue cycle, then returns a registered completion and read data to the winner.

Parameters:
- ADDR_WIDTH, 32, width of the byte address.
- DATA_WIDTH, 32, width of the data words.
- CORE_PRIORITY, 0: 0 selects round-robin; 1 gives the core fixed priority over DMA.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- core_req  input  1  core access request.
- core_we  input  1  1 = store, 0 = load.
- core_funct3  input  3  RISC-V load/store funct3.
- core_addr  input  ADDR_WIDTH  byte address.
- core_wdata  input  DATA_WIDTH  store data.
- core_gnt  output  1  request accepted this cycle.
- core_rvalid  output  1  one-cycle completion pulse.
- core_rdata  output  DATA_WIDTH  load data, valid with core_rvalid.
- core_err  output  1  access error, valid with core_rvalid.
- dma_req, dma_we, dma_funct3, dma_addr, dma_wdata  inputs  same widths as core_*  DMA request.
- dma_gnt, dma_rvalid, dma_rdata, dma_err  outputs  same as core_*  DMA response.
- mem_wr_en  output  1  memory write enable.
- mem_funct3  output  3  to memory funct3.
- mem_addr  output  ADDR_WIDTH  to memory address.
- mem_wdata  output  DATA_WIDTH  to memory write data.
- mem_rdata  input  DATA_WIDTH  combinational read data from memory.

Behaviour:
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- Reset values: all outputs 0, rr pointer = DMA (so the core wins the first tie), all registered request fields 0.
- Grant:
  - x_gnt is combinational from x_req and the state.
  - Grants are allowed only in IDLE or RESP; never in ISSUE.
  - At most one gnt is high per cycle.
  - Accept = req & gnt at a rising edge.
- Arbitration:
  - Only one requester active: it wins.
  - Both active, CORE_PRIORITY=0: the port not granted last wins; the pointer updates on every accept.
  - Both active, CORE_PRIORITY=1: core always wins and the pointer is unused.
- Accept at edge T:
  - Latch winner id, we, funct3, addr, wdata.
  - Next state is ISSUE.
- ISSUE (cycle T+1):
  - mem_addr, mem_funct3 and mem_wdata come from the registered fields. mem_wr_en = registered we.
  - At the closing edge, sample mem_rdata into the winner's rdata register. Write data commits to memory at the same edge.
  - Next state is RESP.
- RESP (cycle T+2):
  - Winner's rvalid = 1 for exactly one cycle, for both loads and stores.
  - Store rdata is don't-care; the register holds the value sampled in ISSUE.
  - A new accept in RESP goes to ISSUE; otherwise the FSM returns to IDLE.
- Latency and throughput:
  - Fixed latency of 2 cycles from accept to rvalid.
  - Maximum throughput is one access per 2 cycles.
- Outside ISSUE:
  - mem_wr_en = 0.
  - mem_addr, mem_funct3 and mem_wdata hold their last registered values.
- Read data hold: x_rdata holds its value until that port's next response. The other port's rdata is unaffected.
- funct3 pass-through: funct3 is forwarded unmodified, including unsigned-load bit 2. Byte/half lane selection and extension belong to the memory.
- A requester that drops req without an accept is ignored; there is no request latching before gnt.
- Reset mid-operation:
  - Asynchronous return to IDLE, mem_wr_en = 0, rvalid = 0. Any in-flight request is discarded.
  - A store in ISSUE with no rising edge before reset asserts is not committed.
- x_err = 0 except as defined under Optional Feature.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - At accept, a halfword access (funct3[1:0]=01) with addr[0]=1 is flagged misaligned.
  - A word access (funct3[1:0]=1x) with addr[1:0]!=00 is flagged misaligned.
  - A flagged request still passes through ISSUE and RESP with the same 2-cycle timing.
  - mem_wr_en is forced to 0 in ISSUE, so no write occurs.
  - In RESP: x_rvalid = 1, x_err = 1, and x_rdata holds its previous value.
- Undefined:
  - No check; core_err and dma_err are tied to 0.
  - Misaligned addresses are forwarded unchanged.

Test Plan:
- Single core store, then load:
  - Stimulus: core_req, we=1, funct3=010, addr=0x10, wdata=0xDEADBEEF; after rvalid, a load with funct3=010, addr=0x10.
  - Response: gnt same cycle as req; mem_wr_en high exactly 1 cycle (T+1); core_rvalid at T+2; load core_rdata=0xDEADBEEF.
- Round-robin:
  - Stimulus: CORE_PRIORITY=0, both req held high for 8 cycles after reset.
  - Response: grants alternate core, dma, core, dma; one accept per 2 cycles; core first.
- Fixed priority:
  - Stimulus: CORE_PRIORITY=1, both req high.
  - Response: dma_gnt never asserts while core_req=1; when core_req drops, DMA is granted the next grant-eligible cycle.
- Byte path:
  - Stimulus: DMA store funct3=000 addr=0x21 wdata=0x000000A5; then core load funct3=000 addr=0x21; then core load funct3=100 addr=0x21.
  - Response: loads return 0xFFFFFFA5 and 0x000000A5 respectively, each on the correct port only.
- Reset mid-issue:
  - Stimulus: assert reset asynchronously in ISSUE of a store addr=0x30 wdata=0x12345678 before the closing edge.
  - Response: mem_wr_en drops immediately; no rvalid; a later load of 0x30 returns the prior contents.
- Misaligned access (DMEM_MISALIGN_CHECK_EN defined):
  - Stimulus: core store funct3=010 addr=0x06.
  - Response: mem_wr_en stays 0; core_rvalid=1 and core_err=1 at T+2.
  - Same stimulus with the macro undefined: the write proceeds and err=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory (synchronous write,
// combinational read) between the core load/store unit and a DMA port.
// Each accepted request is issued to the memory for one cycle, then a
// one-cycle completion pulse with read data returns to the winner.
// Optional build macro: DMEM_MISALIGN_CHECK_EN (misaligned half/word
// accesses are suppressed and answered with an error).
module dmem_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int CORE_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [2:0]            core_funct3,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_err,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [2:0]            dma_funct3,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_err,
  output logic                  mem_wr_en,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  rrDma_q, rrDma_d;
  logic                  winDma_q;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] coreRdata_q;
  logic [DATA_WIDTH-1:0] dmaRdata_q;

  logic                  grantCore, grantDma, accept;
  logic                  selWe;
  logic [2:0]            selFunct3;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selWdata;
  logic                  flagMisalign;

  // Pick the winner; grants only in IDLE/RESP, rrDma_q=1 means DMA won last
  always_comb begin
    grantCore = 1'b0;
    grantDma  = 1'b0;
    if (!reset && state_q != ISSUE) begin
      if (core_req && dma_req) begin
        if (CORE_PRIORITY != 0 || rrDma_q) grantCore = 1'b1;
        else                               grantDma  = 1'b1;
      end else begin
        grantCore = core_req;
        grantDma  = dma_req;
      end
    end
  end

  assign accept = grantCore | grantDma;

  // Route the winning port's request fields toward the request register
  always_comb begin
    selWe     = core_we;
    selFunct3 = core_funct3;
    selAddr   = core_addr;
    selWdata  = core_wdata;
    if (grantDma) begin
      selWe     = dma_we;
      selFunct3 = dma_funct3;
      selAddr   = dma_addr;
      selWdata  = dma_wdata;
    end
  end

  // Next-state logic and round-robin pointer update on every accept
  always_comb begin
    state_d = state_q;
    rrDma_d = rrDma_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = accept ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) rrDma_d = grantDma;
  end

  // State register; pointer starts at DMA so the core wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rrDma_q <= 1'b1;
    end else begin
      state_q <= state_d;
      rrDma_q <= rrDma_d;
    end
  end

  // Capture the accepted request; fields also drive the memory port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      winDma_q <= 1'b0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      winDma_q <= grantDma;
      we_q     <= selWe;
      funct3_q <= selFunct3;
      addr_q   <= selAddr;
      wdata_q  <= selWdata;
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  // Halfword needs addr[0]=0, word (funct3[1]=1) needs addr[1:0]=00
  always_comb begin
    misalign_d = 1'b0;
    if (selFunct3[1])      misalign_d = (selAddr[1:0] != 2'b00);
    else if (selFunct3[0]) misalign_d = selAddr[0];
  end

  // Misalignment flag travels with the accepted request
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       misalign_q <= 1'b0;
    else if (accept) misalign_q <= misalign_d;
  end

  assign flagMisalign = misalign_q;
`else
  assign flagMisalign = 1'b0;
`endif

  // Sample memory read data into the winner's register at the end of ISSUE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coreRdata_q <= '0;
      dmaRdata_q  <= '0;
    end else if (state_q == ISSUE && !flagMisalign) begin
      if (winDma_q) dmaRdata_q  <= mem_rdata;
      else          coreRdata_q <= mem_rdata;
    end
  end

  assign core_gnt    = grantCore;
  assign dma_gnt     = grantDma;
  assign core_rvalid = (state_q == RESP) && !winDma_q;
  assign dma_rvalid  = (state_q == RESP) &&  winDma_q;
  assign core_rdata  = coreRdata_q;
  assign dma_rdata   = dmaRdata_q;
  assign core_err    = core_rvalid & flagMisalign;
  assign dma_err     = dma_rvalid  & flagMisalign;

  assign mem_wr_en   = (state_q == ISSUE) && we_q && !flagMisalign;
  assign mem_funct3  = funct3_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a byte-addressed
// memory model (sync write, combinational read with lane extension).
// A second instance with CORE_PRIORITY=1 covers fixed-priority grants.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;

  logic        core_req, core_we;
  logic [2:0]  core_funct3;
  logic [31:0] core_addr, core_wdata;
  logic        core_gnt, core_rvalid, core_err;
  logic [31:0] core_rdata;
  logic        dma_req, dma_we;
  logic [2:0]  dma_funct3;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid, dma_err;
  logic [31:0] dma_rdata;
  logic        mem_wr_en;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        fCoreReq, fDmaReq;
  logic        fCoreGnt, fCoreRvalid, fCoreErr;
  logic        fDmaGnt, fDmaRvalid, fDmaErr;
  logic [31:0] fCoreRdata, fDmaRdata;
  logic        fMemWrEn;
  logic [2:0]  fMemFunct3;
  logic [31:0] fMemAddr, fMemWdata;
  logic [31:0] fMemRdata = 32'h0;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] memBytes [0:255];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CORE_PRIORITY(0)) u_dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_funct3(core_funct3),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_funct3(dma_funct3),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CORE_PRIORITY(1)) u_fix (
    .clk(clk), .reset(reset),
    .core_req(fCoreReq), .core_we(1'b0), .core_funct3(3'b010),
    .core_addr(32'h0), .core_wdata(32'h0), .core_gnt(fCoreGnt),
    .core_rvalid(fCoreRvalid), .core_rdata(fCoreRdata), .core_err(fCoreErr),
    .dma_req(fDmaReq), .dma_we(1'b0), .dma_funct3(3'b010),
    .dma_addr(32'h4), .dma_wdata(32'h0), .dma_gnt(fDmaGnt),
    .dma_rvalid(fDmaRvalid), .dma_rdata(fDmaRdata), .dma_err(fDmaErr),
    .mem_wr_en(fMemWrEn), .mem_funct3(fMemFunct3), .mem_addr(fMemAddr),
    .mem_wdata(fMemWdata), .mem_rdata(fMemRdata)
  );

  // Memory model: combinational read with byte/half lane extension
  always_comb begin
    logic [7:0]  a;
    logic [31:0] w;
    a = mem_addr[7:0];
    w = {memBytes[a + 8'd3], memBytes[a + 8'd2], memBytes[a + 8'd1], memBytes[a]};
    case (mem_funct3)
      3'b000:  mem_rdata = {{24{w[7]}}, w[7:0]};
      3'b001:  mem_rdata = {{16{w[15]}}, w[15:0]};
      3'b100:  mem_rdata = {24'h0, w[7:0]};
      3'b101:  mem_rdata = {16'h0, w[15:0]};
      default: mem_rdata = w;
    endcase
  end

  // Memory model: synchronous little-endian write
  always @(posedge clk) begin
    if (mem_wr_en) begin
      memBytes[mem_addr[7:0]] <= mem_wdata[7:0];
      if (mem_funct3[1:0] != 2'b00)
        memBytes[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
      if (mem_funct3[1]) begin
        memBytes[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
        memBytes[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One complete access on a single port, checked through issue and response
  task automatic applyStimulus(input bit isDma, input bit we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input bit expWrite, input bit checkData,
                               input logic [31:0] expRdata, input bit expErr);
    @(negedge clk);
    if (isDma) begin
      dma_req = 1'b1; dma_we = we; dma_funct3 = f3; dma_addr = addr; dma_wdata = wdata;
    end else begin
      core_req = 1'b1; core_we = we; core_funct3 = f3; core_addr = addr; core_wdata = wdata;
    end
    #1;
    checkOutput("gntWinner", 32'(isDma ? dma_gnt : core_gnt), 32'd1);
    checkOutput("gntOther",  32'(isDma ? core_gnt : dma_gnt), 32'd0);
    checkOutput("idleRvalid", 32'(core_rvalid | dma_rvalid), 32'd0);
    @(negedge clk);
    core_req = 1'b0;
    dma_req  = 1'b0;
    #1;
    checkOutput("issueWrEn", 32'(mem_wr_en), 32'(expWrite));
    checkOutput("issueAddr", mem_addr, addr);
    checkOutput("issueFunct3", 32'(mem_funct3), 32'(f3));
    checkOutput("issueRvalid", 32'(core_rvalid | dma_rvalid), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("respRvalid", 32'(isDma ? dma_rvalid : core_rvalid), 32'd1);
    checkOutput("respOtherRvalid", 32'(isDma ? core_rvalid : dma_rvalid), 32'd0);
    checkOutput("respErr", 32'(isDma ? dma_err : core_err), 32'(expErr));
    checkOutput("respWrEn", 32'(mem_wr_en), 32'd0);
    if (checkData)
      checkOutput("respRdata", isDma ? dma_rdata : core_rdata, expRdata);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) memBytes[i] = 8'h00;
    reset = 1'b1;
    core_req = 0; core_we = 0; core_funct3 = 0; core_addr = 0; core_wdata = 0;
    dma_req = 0; dma_we = 0; dma_funct3 = 0; dma_addr = 0; dma_wdata = 0;
    fCoreReq = 0; fDmaReq = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rstCoreGnt", 32'(core_gnt), 32'd0);
    checkOutput("rstRvalid", 32'(core_rvalid | dma_rvalid), 32'd0);
    checkOutput("rstWrEn", 32'(mem_wr_en), 32'd0);
    checkOutput("rstMemAddr", mem_addr, 32'd0);
    checkOutput("rstCoreRdata", core_rdata, 32'd0);
    checkOutput("rstErr", 32'(core_err | dma_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Core store then load of the same word
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);

    // Byte path: DMA byte store, core signed and unsigned byte loads
    applyStimulus(1'b1, 1'b1, 3'b000, 32'h21, 32'h000000A5, 1'b1, 1'b1, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h21, 32'h0, 1'b0, 1'b1, 32'hFFFFFFA5, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b100, 32'h21, 32'h0, 1'b0, 1'b1, 32'h000000A5, 1'b0);
    checkOutput("dmaRdataHeld", dma_rdata, 32'h0);

    // Misaligned word store at 0x06, then word load at 0x04
`ifdef DMEM_MISALIGN_CHECK_EN
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h06, 32'hCAFEF00D, 1'b0, 1'b1, 32'h000000A5, 1'b1);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h04, 32'h0, 1'b0, 1'b1, 32'h00000000, 1'b0);
`else
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h06, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h04, 32'h0, 1'b0, 1'b1, 32'hF00D0000, 1'b0);
`endif

    // Reset mid-issue of a store: old contents of 0x30 must survive
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h30, 32'h0BADF00D, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b1; core_funct3 = 3'b010;
    core_addr = 32'h30; core_wdata = 32'h12345678;
    #1;
    checkOutput("midGnt", 32'(core_gnt), 32'd1);
    @(posedge clk);
    #2;
    core_req = 1'b0;
    checkOutput("midIssueWrEn", 32'(mem_wr_en), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("midRstWrEn", 32'(mem_wr_en), 32'd0);
    checkOutput("midRstRvalid", 32'(core_rvalid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checkOutput("midNoRvalid", 32'(core_rvalid | dma_rvalid), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h30, 32'h0, 1'b0, 1'b1, 32'h0BADF00D, 1'b0);

    // Round-robin after reset: core, dma, core, dma, one accept per 2 cycles
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        core_req = 1'b1; core_we = 1'b0; core_funct3 = 3'b010; core_addr = 32'h10;
        dma_req  = 1'b1; dma_we  = 1'b0; dma_funct3  = 3'b100; dma_addr  = 32'h21;
      end
      #1;
      checkOutput($sformatf("rrCoreGnt%0d", i), 32'(core_gnt), 32'((i % 4) == 0));
      checkOutput($sformatf("rrDmaGnt%0d", i), 32'(dma_gnt), 32'((i % 4) == 2));
    end
    @(negedge clk);
    core_req = 1'b0;
    dma_req  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rrCoreRdata", core_rdata, 32'hDEADBEEF);
    checkOutput("rrDmaRdata", dma_rdata, 32'h000000A5);

    // Fixed priority: DMA waits until the core drops its request
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0) begin
        fCoreReq = 1'b1;
        fDmaReq  = 1'b1;
      end
      if (i == 6) fCoreReq = 1'b0;
      #1;
      checkOutput($sformatf("fixCoreGnt%0d", i), 32'(fCoreGnt), 32'(((i % 2) == 0) && (i < 6)));
      checkOutput($sformatf("fixDmaGnt%0d", i), 32'(fDmaGnt), 32'(i == 6));
    end
    @(negedge clk);
    fDmaReq = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
